perm_arbiter: RTL and testbench

//  Round-robin scheduler that shares one perm permutation core among NREQ requesters.

---
 rtl/perm_arbiter.sv | 166 ++++++++++++++++
 tb/tb_perm_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_arbiter.sv
// Round-robin arbiter sharing one perm core among NREQ requesters; a tag FIFO routes output blocks back to their owners.
// Optional sequence checker on err is built only when PERM_ARB_SEQCHK_EN is defined.
module perm_arbiter #(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*200-1:0] req_din,
  output logic [NREQ-1:0]     gnt,
  output logic [2:0]          gnt_ix,
  output logic                perm_pushin,
  output logic [2:0]          perm_dix,
  output logic [199:0]        perm_din,
  input  logic                perm_pushout,
  input  logic [2:0]          perm_doutix,
  input  logic [199:0]        perm_dout,
  output logic [NREQ-1:0]     rsp_push,
  output logic [2:0]          rsp_ix,
  output logic [199:0]        rsp_dout,
  output logic                busy,
  output logic                err
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_reg;
  logic [2:0]      beat_reg;
  logic [IW-1:0]   cur_reg;
  logic [IW-1:0]   rr_last_reg;
  logic [IW-1:0]   tag_mem [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic            issuing;
  logic            eligible;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            do_push;
  logic [IW-1:0]   head;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand_ix;
  logic            found;

  assign issuing    = (state_reg == ISSUE);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(TAG_DEPTH));
  assign eligible   = (|req) && !fifo_full;
  assign head       = tag_mem[rd_ptr_reg];

  assign push    = issuing && (beat_reg == 3'd0);
  assign pop     = perm_pushout && (perm_doutix == 3'd7) && !fifo_empty;
  assign do_push = push && (!fifo_full || pop);

  // Search starts just after the previous winner so the last winner has lowest priority.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    cand_ix = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_ix = IW'((int'(rr_last_reg) + k) % NREQ);
      if (!found && req[cand_ix]) begin
        winner = cand_ix;
        found  = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign gnt[gi]      = issuing && (cur_reg == IW'(gi));
      assign rsp_push[gi] = perm_pushout && !fifo_empty && (head == IW'(gi));
    end
  endgenerate

  assign gnt_ix      = beat_reg;
  assign perm_pushin = issuing;
  assign perm_dix    = beat_reg;
  assign perm_din    = req_din[int'(cur_reg)*200 +: 200];
  assign rsp_ix      = perm_doutix;
  assign rsp_dout    = perm_dout;
  assign busy        = issuing || !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      beat_reg    <= 3'd0;
      cur_reg     <= '0;
      rr_last_reg <= IW'(NREQ - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (eligible) begin
            cur_reg     <= winner;
            rr_last_reg <= winner;
            beat_reg    <= 3'd0;
            state_reg   <= ISSUE;
          end
        end
        default: begin
          if (beat_reg != 3'd7) begin
            beat_reg <= beat_reg + 3'd1;
          end else if (eligible) begin
            cur_reg     <= winner;
            rr_last_reg <= winner;
            beat_reg    <= 3'd0;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) tag_mem[wr_ptr_reg] <= cur_reg;
  end

`ifdef PERM_ARB_SEQCHK_EN
  logic [2:0] exp_ix_reg;
  logic       err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_ix_reg <= 3'd0;
      err_reg    <= 1'b0;
    end else begin
      if (perm_pushout) exp_ix_reg <= exp_ix_reg + 3'd1;
      if ((perm_pushout && fifo_empty) ||
          (perm_pushout && (perm_doutix != exp_ix_reg)) ||
          (push && fifo_full && !pop))
        err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_perm_arbiter.sv
// Randomized bench for perm_arbiter: cycle-level reference model plus a latency-configurable perm stub.
module tb_perm_arbiter;
  localparam int NREQ = 4;
  localparam int TD   = 2;
  localparam int W    = 200;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   req_din;
  logic [NREQ-1:0]     gnt;
  logic [2:0]          gnt_ix;
  logic                perm_pushin;
  logic [2:0]          perm_dix;
  logic [W-1:0]        perm_din;
  logic                perm_pushout;
  logic [2:0]          perm_doutix;
  logic [W-1:0]        perm_dout;
  logic [NREQ-1:0]     rsp_push;
  logic [2:0]          rsp_ix;
  logic [W-1:0]        rsp_dout;
  logic                busy;
  logic                err;

  perm_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TD)) dut (
    .clk(clk), .reset(reset), .req(req), .req_din(req_din),
    .gnt(gnt), .gnt_ix(gnt_ix), .perm_pushin(perm_pushin), .perm_dix(perm_dix),
    .perm_din(perm_din), .perm_pushout(perm_pushout), .perm_doutix(perm_doutix),
    .perm_dout(perm_dout), .rsp_push(rsp_push), .rsp_ix(rsp_ix), .rsp_dout(rsp_dout),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] ix;
    logic [W-1:0] d;
  } beat_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  bit     chk_en  = 0;
  bit     m_issue;
  int     m_beat, m_cur, m_last, m_exp_ix;
  bit     m_err;
  int     tagq[$];
  beat_t  stubq[$];
  bit     pending[NREQ];
  int     lat = 3;
  int     rereq_pct = 0;
  int     cyc = 0;
  bit     t1 = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick_winner();
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_last + k) % NREQ;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_issue = 0; m_beat = 0; m_cur = 0; m_last = NREQ - 1;
    m_exp_ix = 0; m_err = 0;
    tagq.delete();
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++)
      req[i] = pending[i] && !(m_issue && m_cur == i && m_beat == 7);
  endtask

  task automatic drive_inputs();
    beat_t b;
    logic [223:0] rnd;
    for (int i = 0; i < NREQ; i++)
      if (!pending[i] && $urandom_range(99) < rereq_pct) pending[i] = 1;
    drive_req();
    for (int j = 0; j < (NREQ*W)/32; j++) req_din[j*32 +: 32] = $urandom;
    if (t1 && m_issue && m_cur == 0)
      req_din[0 +: W] = (m_beat == 0) ? 200'h60a636261 :
                        (m_beat == 5) ? 200'h8000000000000000000000 : 200'h0;
    if (stubq.size() > 0 && stubq[0].due <= cyc) begin
      b = stubq.pop_front();
      perm_pushout = 1'b1;
      perm_doutix  = b.ix;
      perm_dout    = b.d;
    end else begin
      for (int j = 0; j < 7; j++) rnd[j*32 +: 32] = $urandom;
      perm_pushout = 1'b0;
      perm_doutix  = 3'($urandom);
      perm_dout    = rnd[W-1:0];
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, drive the next inputs.
  task automatic step();
    bit elig, push, pop;
    int w;
    logic [NREQ-1:0] exp_rsp;
    @(negedge clk);
    if (chk_en) begin
      check("gnt", gnt, m_issue ? (1 << m_cur) : 0);
      check("perm_pushin", perm_pushin, m_issue);
      if (m_issue) begin
        check("gnt_ix", gnt_ix, m_beat);
        check("perm_dix", perm_dix, m_beat);
        check("perm_din", perm_din, req_din[m_cur*W +: W]);
      end
      exp_rsp = (perm_pushout && tagq.size() > 0) ? NREQ'(1 << tagq[0]) : '0;
      check("rsp_push", rsp_push, exp_rsp);
      if (perm_pushout) begin
        check("rsp_ix", rsp_ix, perm_doutix);
        check("rsp_dout", rsp_dout, perm_dout);
      end
      check("busy", busy, m_issue || tagq.size() > 0);
      check("err", err, m_err);
    end
    if (perm_pushin) stubq.push_back('{cyc + lat, perm_dix, perm_din});
    if (reset) begin
      model_reset();
      stubq.delete();
    end else begin
      elig = (req != 0) && (tagq.size() < TD);
      w    = pick_winner();
      pop  = perm_pushout && perm_doutix == 3'd7 && tagq.size() > 0;
      push = m_issue && m_beat == 0;
`ifdef PERM_ARB_SEQCHK_EN
      if (perm_pushout && (tagq.size() == 0 || int'(perm_doutix) != m_exp_ix)) m_err = 1;
`endif
      if (perm_pushout) m_exp_ix = (m_exp_ix + 1) % 8;
      if (pop) void'(tagq.pop_front());
      if (push && tagq.size() < TD) tagq.push_back(m_cur);
      if (!m_issue) begin
        if (elig) begin m_cur = w; m_last = w; m_issue = 1; m_beat = 0; end
      end else if (m_beat < 7) begin
        m_beat++;
      end else begin
        pending[m_cur] = 0;
        $display("[TB] block granted to requester %0d at cycle %0d", m_cur, cyc);
        if (elig) begin m_cur = w; m_last = w; m_beat = 0; end
        else m_issue = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit any;
    n = 0;
    forever begin
      any = 0;
      for (int i = 0; i < NREQ; i++) any |= pending[i];
      if (!any && !m_issue && tagq.size() == 0 && stubq.size() == 0) break;
      if (n >= budget) begin
        check("idle_timeout", 0, 1);
        break;
      end
      step();
      n++;
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NREQ; i++) pending[i] = 0;
    reset = 1'b1;
    req = '0; req_din = '0;
    perm_pushout = 1'b0; perm_doutix = 3'd0; perm_dout = '0;
    step();
    chk_en = 1;
    step();
    reset = 1'b0;
    step();
    step();

    // Single requester with directed slice data.
    t1 = 1; pending[0] = 1; drive_req();
    wait_idle(200);
    t1 = 0;

    // Two simultaneous requesters, back-to-back blocks.
    pending[1] = 1; pending[3] = 1; drive_req();
    wait_idle(300);

    // All requesters held continuously.
    rereq_pct = 100;
    for (int i = 0; i < NREQ; i++) pending[i] = 1;
    drive_req();
    for (int i = 0; i < 48; i++) step();
    rereq_pct = 0;
    wait_idle(400);

    // Long perm latency so the tag FIFO fills and throttles grants.
    lat = 40;
    pending[0] = 1; pending[1] = 1; pending[2] = 1; drive_req();
    wait_idle(600);
    lat = 3;

    // Reset in the middle of requester 2's block.
    pending[2] = 1; drive_req();
    for (int n = 0; n < 100 && !(m_issue && m_cur == 2 && m_beat == 3); n++) step();
    check("reach_mid_grant", m_issue && m_cur == 2 && m_beat == 3, 1);
    reset = 1'b1; pending[0] = 1; drive_req();
    step();
    reset = 1'b0;
    step();
    wait_idle(300);

    // Randomized traffic over several perm latencies.
    for (int ph = 0; ph < 4; ph++) begin
      lat = $urandom_range(12, 1);
      rereq_pct = 25;
      for (int i = 0; i < 400; i++) step();
      rereq_pct = 0;
      wait_idle(800);
    end
    lat = 3;

    // Spurious perm output with nothing in flight.
    perm_pushout = 1'b1; perm_doutix = 3'd0;
    step();
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
